// File: rtl/led_fade_master.sv
// Wishbone master that fades the RGB LED PWM registers toward a target colour.
// One step per prescaler tick; each changed channel is written in R, G, B order.
module led_fade_master #(
    parameter int unsigned STEP_DIV  = 1000,
    parameter int unsigned STEP_SIZE = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        tgt_valid_i,
    output logic        tgt_ready_o,
    input  logic [23:0] tgt_rgb_i,
    output logic [23:0] color_o,
    output logic        busy_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_adr_o,
    output logic [7:0]  wb_dat_o,
    input  logic        wb_ack_i
);

    localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(STEP_DIV - 1);
    localparam logic [8:0] STEP9 = 9'(STEP_SIZE);

    typedef enum logic [1:0] {
        IDLE,
        WR_R,
        WR_G,
        WR_B
    } state_e;

    state_e         state_q, state_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic [23:0]    cur_q, cur_d;
    logic [23:0]    tgt_q, tgt_d;
    logic [2:0]     chg_q, chg_d;
    logic           gap_q, gap_d;

    logic           tick;
    logic           stb_act;
    logic           acked;
    logic [23:0]    nxt;
    logic [2:0]     mask;

    function automatic logic [7:0] step_ch(input logic [7:0] c,
                                           input logic [7:0] t);
        logic [8:0] c9;
        logic [8:0] t9;
        c9 = {1'b0, c};
        t9 = {1'b0, t};
        if (c9 < t9) begin
            step_ch = ((t9 - c9) > STEP9) ? 8'(c9 + STEP9) : t;
        end else if (c9 > t9) begin
            step_ch = ((c9 - t9) > STEP9) ? 8'(c9 - STEP9) : t;
        end else begin
            step_ch = c;
        end
    endfunction

    assign tick = (presc_q == PMAX);

    assign nxt[23:16] = step_ch(cur_q[23:16], tgt_q[23:16]);
    assign nxt[15:8]  = step_ch(cur_q[15:8],  tgt_q[15:8]);
    assign nxt[7:0]   = step_ch(cur_q[7:0],   tgt_q[7:0]);

    assign mask[2] = (nxt[23:16] != cur_q[23:16]);
    assign mask[1] = (nxt[15:8]  != cur_q[15:8]);
    assign mask[0] = (nxt[7:0]   != cur_q[7:0]);

    // gap_q marks the forced idle bus cycle between two writes
    assign stb_act = (state_q != IDLE) && !gap_q;
    assign acked   = stb_act && wb_ack_i;

    always_comb begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        state_d = state_q;
        cur_d   = cur_q;
        tgt_d   = tgt_q;
        chg_d   = chg_q;
        gap_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (tgt_valid_i) begin
                    tgt_d = tgt_rgb_i;
                end
                if (tick) begin
                    cur_d = nxt;
                    chg_d = mask;
                    if (mask[2]) begin
                        state_d = WR_R;
                    end else if (mask[1]) begin
                        state_d = WR_G;
                    end else if (mask[0]) begin
                        state_d = WR_B;
                    end
                end
            end
            WR_R: begin
                if (acked) begin
                    if (chg_q[1]) begin
                        state_d = WR_G;
                    end else if (chg_q[0]) begin
                        state_d = WR_B;
                    end else begin
                        state_d = IDLE;
                    end
                    gap_d = (state_d != IDLE);
                end
            end
            WR_G: begin
                if (acked) begin
                    state_d = chg_q[0] ? WR_B : IDLE;
                    gap_d   = (state_d != IDLE);
                end
            end
            WR_B: begin
                if (acked) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            presc_q <= '0;
            cur_q   <= '0;
            tgt_q   <= '0;
            chg_q   <= '0;
            gap_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            cur_q   <= cur_d;
            tgt_q   <= tgt_d;
            chg_q   <= chg_d;
            gap_q   <= gap_d;
        end
    end

    always_comb begin
        wb_adr_o = 4'd0;
        wb_dat_o = 8'd0;
        if (stb_act) begin
            unique case (state_q)
                WR_R: begin
                    wb_adr_o = 4'd0;
                    wb_dat_o = cur_q[23:16];
                end
                WR_G: begin
                    wb_adr_o = 4'd1;
                    wb_dat_o = cur_q[15:8];
                end
                WR_B: begin
                    wb_adr_o = 4'd2;
                    wb_dat_o = cur_q[7:0];
                end
                default: begin
                    wb_adr_o = 4'd0;
                    wb_dat_o = 8'd0;
                end
            endcase
        end
    end

    assign wb_cyc_o    = stb_act;
    assign wb_stb_o    = stb_act;
    assign wb_we_o     = stb_act;
    assign tgt_ready_o = (state_q == IDLE);
    assign color_o     = cur_q;
    assign busy_o      = (state_q != IDLE) || (cur_q != tgt_q);

endmodule
